// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: one full-subtractor slice walks the operands LSB-first,
// one bit per clock, with a valid/ready handshake on both the operand and result sides.
module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;

  assign d  = a_sr[0] ^ b_sr[0] ^ br;
  assign bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  // D is shifted in from the top so the LSB computed first ends up at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          D    <= (D >> 1) | (WIDTH'(d) << (WIDTH - 1));
          br   <= bo;
          if (cnt == LAST) begin
            Bout  <= bo;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Randomized self-checking bench for serial_subtract_ctrl: an arithmetic reference model
// predicts handshake outputs and results every cycle, plus directed literal cases.
module tb_serial_subtract_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;
  bit checkEnable = 1'b0;

  int         mRunLeft  = 0;
  bit         mDone     = 1'b0;
  logic [8:0] mResult   = '0;
  logic [7:0] mHeldD    = '0;
  logic       mHeldBout = 1'b0;

  int cycle      = 0;
  int lastAccept = -1000;
  int dutAccepts = 0;

  serial_subtract_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result is plain modular arithmetic, ready WIDTH clocks after accept.
  initial forever begin
    @(posedge clk);
    cycle++;
    if (rst) begin
      mRunLeft  = 0;
      mDone     = 1'b0;
      mHeldD    = '0;
      mHeldBout = 1'b0;
    end else if (mDone) begin
      if (out_ready) mDone = 1'b0;
    end else if (mRunLeft > 0) begin
      mRunLeft--;
      if (mRunLeft == 0) begin
        mDone     = 1'b1;
        mHeldD    = mResult[7:0];
        mHeldBout = mResult[8];
      end
    end else if (in_valid) begin
      mResult  = {1'b0, A} - {1'b0, B} - 9'(Bin);
      mRunLeft = WIDTH;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) lastAccept = -1000;
    if (checkEnable && !rst) begin
      checkOutput("in_ready", in_ready, (!mDone && mRunLeft == 0));
      checkOutput("out_valid", out_valid, mDone);
      checkOutput("busy", busy, (mDone || mRunLeft != 0));
      if (mRunLeft == 0) begin
        checkOutput("D", D, mHeldD);
        checkOutput("Bout", Bout, mHeldBout);
      end
      if (in_ready && in_valid) begin
        if (lastAccept > -1000)
          checkOutput("accept_spacing", ((cycle - lastAccept) >= WIDTH + 2), 1);
        lastAccept = cycle;
        dutAccepts++;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [7:0] expD, input logic expBout);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: out_valid not seen within %0d cycles", name, n);
    end
    checkOutput({name, "_D"}, D, expD);
    checkOutput({name, "_Bout"}, Bout, expBout);
    checkOutput({name, "_model"}, mHeldD, expD);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] holdD;
    logic       holdBout;
    logic [7:0] vecA [3] = '{8'h00, 8'h80, 8'hFF};
    logic [7:0] vecB [3] = '{8'h01, 8'h7F, 8'hFF};
    logic       vecC [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] vecD [3] = '{8'hFF, 8'h00, 8'hFF};
    logic       vecO [3] = '{1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Bin = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    checkEnable = 1'b1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_D", D, 0);
    checkOutput("rst_Bout", Bout, 0);

    $display("[TB] basic op with latency check");
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) checkOutput("lat_early", out_valid, 0);
      if (i == 8) begin
        checkOutput("lat_valid", out_valid, 1);
        checkOutput("t1_D", D, 8'h1E);
        checkOutput("t1_Bout", Bout, 0);
      end
    end
    tick();
    checkOutput("t1_pulse_end", out_valid, 0);
    checkOutput("t1_idle", in_ready, 1);

    $display("[TB] borrow corner cases");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(vecA[k], vecB[k], vecC[k]);
      waitResult("corner", vecD[k], vecO[k]);
      tick();
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b1);
    waitResult("bp", 8'hDD, 1'b1);
    holdD = D;
    holdBout = Bout;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A = 8'($urandom);
      B = 8'($urandom);
      tick();
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_D", D, 8'hDD);
      checkOutput("bp_Bout", Bout, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_ready", in_ready, 1);
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_held_D", D, holdD);
    checkOutput("bp_held_Bout", Bout, holdBout);

    $display("[TB] operand hold-off");
    applyStimulus(8'hC3, 8'h47, 1'b0);
    for (int i = 0; i < 6; i++) begin
      A = 8'($urandom);
      B = 8'($urandom);
      Bin = 1'($urandom);
      tick();
    end
    waitResult("holdoff", 8'h7C, 1'b0);
    tick();

    $display("[TB] reset mid-run");
    applyStimulus(8'h55, 8'h11, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_in_ready", in_ready, 1);
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_D", D, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("mrst_no_pulse", out_valid, 0);
    end
    applyStimulus(8'h10, 8'h01, 1'b0);
    waitResult("after_rst", 8'h0F, 1'b0);
    tick();

    $display("[TB] random traffic");
    begin
      int startAccepts = dutAccepts;
      for (int c = 0; c < 40000 && (dutAccepts - startAccepts) < 1000; c++) begin
        A = 8'($urandom);
        B = 8'($urandom);
        Bin = 1'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = 1'($urandom);
        tick();
      end
      if ((dutAccepts - startAccepts) < 1000) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL random_accepts: got %0d expected 1000", dutAccepts - startAccepts);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (15) tick();
    checkOutput("drain_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
